// File: rtl/reg_bank_sequencer.sv
// Command-driven write/read master for the 8 x 16-bit register bank (WRITE/READ/MOVE/SWAP).
// Optional SWAP datapath is built only when REGSEQ_SWAP_EN is defined; otherwise op 11 answers with rsp_err.
module reg_bank_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ID_W-1:0]  cmd_a,
  input  logic [ID_W-1:0]  cmd_b,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] bank_din,
  output logic [ID_W-1:0]  bank_id,
  output logic             bank_ld,
  input  logic [WIDTH-1:0] bank_dout,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_MOVE = 2'b10, OP_SWAP = 2'b11} op_t;

  state_t           state, state_n;
  op_t              op_q;
  logic [ID_W-1:0]  a_q, b_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] tmp_a, tmp_a_n;
  logic [WIDTH-1:0] din_n;
  logic [ID_W-1:0]  id_n;
  logic             ld_n;
  logic             rv_n;
  logic [WIDTH-1:0] rd_n;
  logic             re_n;
  logic             accept;
`ifdef REGSEQ_SWAP_EN
  logic [WIDTH-1:0] tmp_b, tmp_b_n;
`endif

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Bank and response outputs are computed one state ahead so they are loaded
  // on the edge entering the state that uses them.
  always_comb begin
    state_n = state;
    din_n   = bank_din;
    id_n    = bank_id;
    ld_n    = 1'b0;
    rv_n    = 1'b0;
    rd_n    = rsp_data;
    re_n    = rsp_err;
    tmp_a_n = tmp_a;
`ifdef REGSEQ_SWAP_EN
    tmp_b_n = tmp_b;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          id_n = cmd_a;
          if (op_t'(cmd_op) == OP_WRITE) begin
            state_n = WR_A;
            din_n   = cmd_data;
            ld_n    = 1'b1;
          end else begin
            state_n = RD_A;
          end
        end
      end
      RD_A: begin
        tmp_a_n = bank_dout;
        case (op_q)
          OP_MOVE: begin
            state_n = WR_B;
            id_n    = b_q;
            din_n   = bank_dout;
            ld_n    = 1'b1;
          end
`ifdef REGSEQ_SWAP_EN
          OP_SWAP: begin
            state_n = RD_B;
            id_n    = b_q;
          end
`else
          OP_SWAP: begin
            state_n = DONE;
            rv_n    = 1'b1;
            rd_n    = '0;
            re_n    = 1'b1;
          end
`endif
          default: begin
            state_n = DONE;
            rv_n    = 1'b1;
            rd_n    = bank_dout;
            re_n    = 1'b0;
          end
        endcase
      end
`ifdef REGSEQ_SWAP_EN
      RD_B: begin
        tmp_b_n = bank_dout;
        state_n = WR_A;
        id_n    = a_q;
        din_n   = bank_dout;
        ld_n    = 1'b1;
      end
      WR_A: begin
        if (op_q == OP_SWAP) begin
          state_n = WR_B;
          id_n    = b_q;
          din_n   = tmp_a;
          ld_n    = 1'b1;
        end else begin
          state_n = DONE;
          rv_n    = 1'b1;
          rd_n    = data_q;
          re_n    = 1'b0;
        end
      end
`else
      WR_A: begin
        state_n = DONE;
        rv_n    = 1'b1;
        rd_n    = data_q;
        re_n    = 1'b0;
      end
`endif
      WR_B: begin
        state_n = DONE;
        rv_n    = 1'b1;
        rd_n    = tmp_a;
        re_n    = 1'b0;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_WRITE;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      tmp_a     <= '0;
      bank_din  <= '0;
      bank_id   <= '0;
      bank_ld   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      tmp_a     <= tmp_a_n;
      bank_din  <= din_n;
      bank_id   <= id_n;
      bank_ld   <= ld_n;
      rsp_valid <= rv_n;
      rsp_data  <= rd_n;
      rsp_err   <= re_n;
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        data_q <= cmd_data;
      end
    end
  end

`ifdef REGSEQ_SWAP_EN
  always_ff @(posedge clk) begin
    if (reset) tmp_b <= '0;
    else       tmp_b <= tmp_b_n;
  end
`endif

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed, table-driven bench for reg_bank_sequencer with a behavioural 8 x 16 register bank.
module tb_reg_bank_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_a, cmd_b;
  logic [15:0] cmd_data;
  logic [15:0] bank_din;
  logic [2:0]  bank_id;
  logic        bank_ld;
  logic [15:0] bank_dout;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_bank_sequencer #(.WIDTH(16), .ID_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .bank_din(bank_din), .bank_id(bank_id), .bank_ld(bank_ld), .bank_dout(bank_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  logic [15:0] regs [8];
  always @(posedge clk) if (bank_ld) regs[bank_id] <= bank_din;
  assign bank_dout = regs[bank_id];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  a, b;
    logic [15:0] data;
    int          lat;
    logic [15:0] rsp;
    logic        err;
    int          nld;
    logic [2:0]  id1;
    logic [15:0] din1;
    logic [2:0]  id2;
    logic [15:0] din2;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                              input logic [15:0] data, input int lat, input logic [15:0] rsp,
                              input logic err, input int nld, input logic [2:0] id1,
                              input logic [15:0] din1, input logic [2:0] id2, input logic [15:0] din2);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.data = data; v.lat = lat; v.rsp = rsp; v.err = err;
    v.nld = nld; v.id1 = id1; v.din1 = din1; v.id2 = id2; v.din2 = din2;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, cmd_ready, 1);
  endtask

  task automatic run(input vec_t t, input int idx);
    int got = 0, nld = 0;
    logic busy_ready = 1'b0;
    logic [2:0] id1 = '0, id2 = '0;
    logic [15:0] din1 = '0, din2 = '0;
    string nm;
    nm = $sformatf("vec%0d", idx);
    wait_ready(nm);
    cmd_valid = 1'b1; cmd_op = t.op; cmd_a = t.a; cmd_b = t.b; cmd_data = t.data;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = ~t.a; cmd_b = ~t.b; cmd_data = ~t.data; cmd_op = ~t.op;
    for (int k = 1; k <= 12; k++) begin
      if (bank_ld) begin
        nld++;
        if (nld == 1) begin id1 = bank_id; din1 = bank_din; end
        else begin id2 = bank_id; din2 = bank_din; end
      end
      if (cmd_ready) busy_ready = 1'b1;
      if (rsp_valid) begin
        got = k;
        break;
      end
      @(negedge clk);
    end
    chk({nm, " latency"}, got, t.lat);
    chk({nm, " rsp_data"}, rsp_data, t.rsp);
    chk({nm, " rsp_err"}, rsp_err, t.err);
    chk({nm, " ld_count"}, nld, t.nld);
    chk({nm, " busy_ready"}, busy_ready, 0);
    if (t.nld >= 1) begin
      chk({nm, " ld1_id"}, id1, t.id1);
      chk({nm, " ld1_din"}, din1, t.din1);
    end
    if (t.nld >= 2) begin
      chk({nm, " ld2_id"}, id2, t.id2);
      chk({nm, " ld2_din"}, din2, t.din2);
    end
    @(negedge clk);
    chk({nm, " rsp_pulse"}, rsp_valid, 0);
    chk({nm, " idle_ready"}, cmd_ready, 1);
    chk({nm, " rsp_hold"}, rsp_data, t.rsp);
  endtask

  task automatic reset_mid(input string nm, input logic [1:0] op, input logic [2:0] a,
                           input logic [2:0] b, input int rc, input logic exp_ld);
    int seen = 0;
    wait_ready(nm);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = 16'h5A5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= rc; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk({nm, " ld_at_reset"}, bank_ld, exp_ld);
    reset = 1'b1;
    @(negedge clk);
    chk({nm, " rst bank_ld"}, bank_ld, 0);
    chk({nm, " rst bank_id"}, bank_id, 0);
    chk({nm, " rst bank_din"}, bank_din, 0);
    chk({nm, " rst rsp_valid"}, rsp_valid, 0);
    chk({nm, " rst rsp_data"}, rsp_data, 0);
    chk({nm, " rst rsp_err"}, rsp_err, 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (bank_ld) seen++;
    end
    chk({nm, " no_rsp_or_ld"}, seen, 0);
    chk({nm, " ready_after"}, cmd_ready, 1);
  endtask

  vec_t vt [18];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nld, nrdy;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_data = '0;

    vt[0]  = mk(2'b00, 3'd3, 3'd0, 16'hBEEF, 2, 16'hBEEF, 0, 1, 3'd3, 16'hBEEF, 0, 0);
    vt[1]  = mk(2'b00, 3'd5, 3'd1, 16'h1234, 2, 16'h1234, 0, 1, 3'd5, 16'h1234, 0, 0);
    vt[2]  = mk(2'b00, 3'd1, 3'd2, 16'h00AA, 2, 16'h00AA, 0, 1, 3'd1, 16'h00AA, 0, 0);
    vt[3]  = mk(2'b00, 3'd2, 3'd0, 16'h1111, 2, 16'h1111, 0, 1, 3'd2, 16'h1111, 0, 0);
    vt[4]  = mk(2'b00, 3'd7, 3'd0, 16'h2222, 2, 16'h2222, 0, 1, 3'd7, 16'h2222, 0, 0);
    vt[5]  = mk(2'b00, 3'd0, 3'd0, 16'hFFFF, 2, 16'hFFFF, 0, 1, 3'd0, 16'hFFFF, 0, 0);
    vt[6]  = mk(2'b01, 3'd5, 3'd3, 16'h0000, 2, 16'h1234, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(2'b10, 3'd1, 3'd6, 16'h0000, 3, 16'h00AA, 0, 1, 3'd6, 16'h00AA, 0, 0);
    vt[8]  = mk(2'b01, 3'd6, 3'd0, 16'h0000, 2, 16'h00AA, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(2'b01, 3'd1, 3'd0, 16'h0000, 2, 16'h00AA, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(2'b10, 3'd5, 3'd5, 16'h0000, 3, 16'h1234, 0, 1, 3'd5, 16'h1234, 0, 0);
    vt[11] = mk(2'b01, 3'd5, 3'd0, 16'h0000, 2, 16'h1234, 0, 0, 0, 0, 0, 0);
`ifdef REGSEQ_SWAP_EN
    vt[12] = mk(2'b11, 3'd2, 3'd7, 16'h0000, 5, 16'h1111, 0, 2, 3'd2, 16'h2222, 3'd7, 16'h1111);
    vt[13] = mk(2'b01, 3'd2, 3'd0, 16'h0000, 2, 16'h2222, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(2'b01, 3'd7, 3'd0, 16'h0000, 2, 16'h1111, 0, 0, 0, 0, 0, 0);
    vt[15] = mk(2'b11, 3'd3, 3'd3, 16'h0000, 5, 16'hBEEF, 0, 2, 3'd3, 16'hBEEF, 3'd3, 16'hBEEF);
`else
    vt[12] = mk(2'b11, 3'd2, 3'd7, 16'h0000, 2, 16'h0000, 1, 0, 0, 0, 0, 0);
    vt[13] = mk(2'b01, 3'd2, 3'd0, 16'h0000, 2, 16'h1111, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(2'b01, 3'd7, 3'd0, 16'h0000, 2, 16'h2222, 0, 0, 0, 0, 0, 0);
    vt[15] = mk(2'b11, 3'd3, 3'd3, 16'h0000, 2, 16'h0000, 1, 0, 0, 0, 0, 0);
`endif
    vt[16] = mk(2'b01, 3'd3, 3'd0, 16'h0000, 2, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(2'b01, 3'd0, 3'd0, 16'h0000, 2, 16'hFFFF, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset bank_ld", bank_ld, 0);
    chk("reset bank_id", bank_id, 0);
    chk("reset bank_din", bank_din, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) run(vt[i], i);

    chk("model r1 after move", regs[1], 16'h00AA);
    chk("model r6 after move", regs[6], 16'h00AA);

    // Valid held high: a WRITE is re-accepted once per IDLE visit (every 3 cycles).
    wait_ready("held");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 3'd4; cmd_b = 3'd0; cmd_data = 16'h4444;
    nld = 0; nrdy = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bank_ld) nld++;
      if (cmd_ready) nrdy++;
    end
    cmd_valid = 1'b0;
    chk("held ld_count", nld, 3);
    chk("held ready_count", nrdy, 3);
    @(negedge clk);
    chk("held r4", regs[4], 16'h4444);
    @(negedge clk);

`ifdef REGSEQ_SWAP_EN
    reset_mid("rst_swap", 2'b11, 3'd0, 3'd3, 3, 1'b1);
    chk("rst_swap r_a written", regs[0], 16'hBEEF);
    chk("rst_swap r_b unchanged", regs[3], 16'hBEEF);
    reset_mid("rst_move_rd", 2'b10, 3'd5, 3'd0, 1, 1'b0);
    chk("rst_move_rd r0 unchanged", regs[0], 16'hBEEF);
`else
    reset_mid("rst_move_wr", 2'b10, 3'd0, 3'd3, 2, 1'b1);
    chk("rst_move_wr r3 written", regs[3], 16'hFFFF);
    chk("rst_move_wr r0 unchanged", regs[0], 16'hFFFF);
    reset_mid("rst_move_rd", 2'b10, 3'd5, 3'd0, 1, 1'b0);
    chk("rst_move_rd r0 unchanged", regs[0], 16'hFFFF);
`endif

    run(vt[11], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
